// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU slice and its multi-precision sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package alu4_pkg;

   // Sequencer control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // ALU opcodes
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_ROL = 4'h5;
   localparam logic [3:0] OP_ROR = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;

   // Bit n set when opcode n moves data towards the LSB (rotate/shift right).
   // Those opcodes must walk the word MSB-first so the rotate carry chains correctly.
   localparam logic [15:0] RIGHT_OPS = 16'h0140;

   function automatic logic op_is_right(input logic [3:0] op);
      return RIGHT_OPS[op];
   endfunction

endpackage

// File: rtl/alu4_seq_nib_mux.sv
// Nibble select (operands A/B) and nibble insert (result word) by index k.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module alu4_seq_nib_mux #(
   parameter int NIBBLES = 4,
   parameter int KW      = 2
) (
   input  logic [4*NIBBLES-1:0] word_a,
   input  logic [4*NIBBLES-1:0] word_b,
   input  logic [4*NIBBLES-1:0] word_res,
   input  logic [KW-1:0]        k,
   input  logic [3:0]           nib_in,
   output logic [3:0]           nib_a,
   output logic [3:0]           nib_b,
   output logic [4*NIBBLES-1:0] word_ins
);

   // Pick nibble k of A and B, and overwrite nibble k of the result word with nib_in
   always_comb begin
      nib_a    = '0;
      nib_b    = '0;
      word_ins = word_res;
      for (int i = 0; i < NIBBLES; i++) begin
         if (k == KW'(i)) begin
            nib_a              = word_a[i*4 +: 4];
            nib_b              = word_b[i*4 +: 4];
            word_ins[i*4 +: 4] = nib_in;
         end
      end
   end

endmodule

// File: rtl/alu4_seq.sv
// Multi-precision sequencer: feeds one wide command through the 4-bit ALU a nibble per cycle.
// Latency: accept edge, NIBBLES EXEC cycles, then res_valid; no overlap between commands.
// Backpressure: cmd_ready only in IDLE; result held stable in DONE until res_ready. Optional abort: ALU4_SEQ_ABORT_EN.
module alu4_seq
   import alu4_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic [4*NIBBLES-1:0] cmd_a,
   input  logic [4*NIBBLES-1:0] cmd_b,
   input  logic                 cmd_mcin,
   input  logic                 cmd_rcin,
`ifdef ALU4_SEQ_ABORT_EN
   input  logic                 cmd_abort,
`endif
   output logic [3:0]           alu_op,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic                 alu_mcin,
   output logic                 alu_rcin,
   input  logic [3:0]           alu_out,
   input  logic                 alu_mco,
   input  logic                 alu_rco,
   input  logic                 alu_ovf,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [4*NIBBLES-1:0] res_data,
   output logic                 res_mco,
   output logic                 res_rco,
   output logic                 res_zero,
   output logic                 res_ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

   state_t          state_q, state_d;
   logic [KW-1:0]   cnt_q;
   logic [3:0]      op_q;
   logic [W-1:0]    a_q, b_q;
   logic [W-1:0]    work_q;     // result under assembly
   logic [W-1:0]    res_q;      // last committed result
   logic            mcin_q, rcin_q;
   logic            mco_q, rco_q, zero_q, ovf_q;
   logic            in_exec;
   logic            abort_w;
   logic [KW-1:0]   k;
   logic [3:0]      nib_a, nib_b;
   logic [W-1:0]    work_ins;

`ifdef ALU4_SEQ_ABORT_EN
   assign abort_w = cmd_abort;
`else
   assign abort_w = 1'b0;
`endif

   assign in_exec = (state_q == EXEC);

   // Right-moving opcodes start at the top nibble so the rotate carry flows downwards
   assign k = op_is_right(op_q) ? (LAST - cnt_q) : cnt_q;

   alu4_seq_nib_mux #(
      .NIBBLES (NIBBLES),
      .KW      (KW)
   ) u_nib_mux (
      .word_a   (a_q),
      .word_b   (b_q),
      .word_res (work_q),
      .k        (k),
      .nib_in   (alu_out),
      .nib_a    (nib_a),
      .nib_b    (nib_b),
      .word_ins (work_ins)
   );

   // First nibble takes the command's carries; later nibbles take the previous nibble's carry-outs
   assign alu_op    = in_exec ? op_q  : 4'd0;
   assign alu_a     = in_exec ? nib_a : 4'd0;
   assign alu_b     = in_exec ? nib_b : 4'd0;
   assign alu_mcin  = in_exec & ((cnt_q == '0) ? mcin_q : mco_q);
   assign alu_rcin  = in_exec & ((cnt_q == '0) ? rcin_q : rco_q);

   assign cmd_ready = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign res_data  = res_q;
   assign res_mco   = mco_q;
   assign res_rco   = rco_q;
   assign res_zero  = zero_q;
   assign res_ovf   = ovf_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accept, walk NIBBLES nibbles (abortable), hold result until consumed
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid)            state_d = EXEC;
         EXEC:    if (abort_w)              state_d = IDLE;
                  else if (cnt_q == LAST)   state_d = DONE;
         DONE:    if (res_ready)            state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // Datapath: latch the command on accept, accumulate one nibble per EXEC edge, commit on the last
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         work_q <= '0;
         res_q  <= '0;
         mcin_q <= 1'b0;
         rcin_q <= 1'b0;
         mco_q  <= 1'b0;
         rco_q  <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  a_q    <= cmd_a;
                  b_q    <= cmd_b;
                  mcin_q <= cmd_mcin;
                  rcin_q <= cmd_rcin;
                  cnt_q  <= '0;
                  zero_q <= 1'b1;
               end
            end
            EXEC: begin
               if (!abort_w) begin
                  work_q <= work_ins;
                  mco_q  <= alu_mco;
                  rco_q  <= alu_rco;
                  zero_q <= zero_q & (alu_out == 4'd0);
                  ovf_q  <= alu_ovf;
                  cnt_q  <= cnt_q + KW'(1);
                  if (cnt_q == LAST) res_q <= work_ins;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu4_seq.sv
// Self-checking bench for alu4_seq with a behavioural 4-bit ALU and a wide-word reference model.
// Latency: n/a.
// Backpressure: exercises res_ready stalls, mid-operation reset and (with ALU4_SEQ_ABORT_EN) abort.
module tb_alu4_seq;
   import alu4_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   typedef struct packed {
      logic [W-1:0] data;
      logic         mco;
      logic         rco;
      logic         zero;
      logic         ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [W-1:0]  cmd_a, cmd_b;
   logic          cmd_mcin, cmd_rcin;
`ifdef ALU4_SEQ_ABORT_EN
   logic          cmd_abort;
`endif
   logic [3:0]    alu_op, alu_a, alu_b;
   logic          alu_mcin, alu_rcin;
   logic [3:0]    alu_out;
   logic          alu_mco, alu_rco, alu_ovf;
   logic          res_valid, res_ready;
   logic [W-1:0]  res_data;
   logic          res_mco, res_rco, res_zero, res_ovf;
   logic [4:0]    sum5;

   int            n_checks = 0;
   int            n_err    = 0;
   exp_t          exp_q[$];
   int            lat;
   logic [15:0]   tr_a;
   logic [3:0]    tr_mc;

   always #5 clk = ~clk;

   alu4_seq #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_mcin  (cmd_mcin),
      .cmd_rcin  (cmd_rcin),
`ifdef ALU4_SEQ_ABORT_EN
      .cmd_abort (cmd_abort),
`endif
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_mcin  (alu_mcin),
      .alu_rcin  (alu_rcin),
      .alu_out   (alu_out),
      .alu_mco   (alu_mco),
      .alu_rco   (alu_rco),
      .alu_ovf   (alu_ovf),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_mco   (res_mco),
      .res_rco   (res_rco),
      .res_zero  (res_zero),
      .res_ovf   (res_ovf)
   );

   // 4-bit ALU slice model
   always_comb begin
      sum5    = '0;
      alu_out = '0;
      alu_mco = alu_mcin;
      alu_rco = alu_rcin;
      alu_ovf = 1'b0;
      case (alu_op)
         OP_ADD: begin
            sum5    = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_mcin};
            alu_out = sum5[3:0];
            alu_mco = sum5[4];
            alu_ovf = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
         end
         OP_ROR: begin
            alu_out = {alu_rcin, alu_a[3:1]};
            alu_rco = alu_a[0];
         end
         OP_XOR:  alu_out = alu_a ^ alu_b;
         default: ;
      endcase
   end

   // Whole-word reference: what the full-width operation must yield
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic mc, input logic rc);
      exp_t       e;
      logic [W:0] s;
      e   = '0;
      s   = '0;
      e.mco = mc;
      e.rco = rc;
      case (op)
         OP_ADD: begin
            s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, mc};
            e.data = s[W-1:0];
            e.mco  = s[W];
            e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
         end
         OP_ROR: begin
            e.data = {rc, a[W-1:1]};
            e.rco  = a[0];
         end
         OP_XOR:  e.data = a ^ b;
         default: ;
      endcase
      e.zero = (e.data == '0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a command, wait for accept, trace issued nibbles, stop in the cycle res_valid rises
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mc, input logic rc);
      int n;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_mcin = mc; cmd_rcin = rc;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         lat = -1;
         return;
      end
      exp_q.push_back(model(op, a, b, mc, rc));
      tick();
      cmd_valid = 1'b0;
      tr_a  = '0;
      tr_mc = '0;
      lat   = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i <= NIB) begin
            tr_a  = {tr_a[11:0], alu_a};
            tr_mc = {tr_mc[2:0], alu_mcin};
         end
         if (res_valid) begin
            lat = i;
            break;
         end
         tick();
      end
      if (lat < 0) check("result_timeout", 32'(res_valid), 32'd1);
   endtask

   // Every cycle a result is on offer it must match the oldest outstanding command
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL spurious_res_valid: got res_data 0x%0h with no command outstanding", res_data);
         end else begin
            check("cmp_data", 32'(res_data), 32'(exp_q[0].data));
            check("cmp_flags", {28'd0, res_mco, res_rco, res_zero, res_ovf},
                  {28'd0, exp_q[0].mco, exp_q[0].rco, exp_q[0].zero, exp_q[0].ovf});
            check("cmp_ready_low", 32'(cmd_ready), 32'd0);
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_mcin = 1'b0; cmd_rcin = 1'b0; res_ready = 1'b1;
`ifdef ALU4_SEQ_ABORT_EN
      cmd_abort = 1'b0;
`endif
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_flags", {28'd0, res_mco, res_rco, res_zero, res_ovf}, 32'd0);
      check("rst_alu_drive", {20'd0, alu_op, alu_a, alu_b}, 32'd0);
      check("rst_alu_carry", {30'd0, alu_mcin, alu_rcin}, 32'd0);

      // ADD with a carry rippling into nibble 2
      send(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      check("add1_latency", 32'(lat), 32'd5);
      check("add1_data", 32'(res_data), 32'h0100);
      check("add1_mco", 32'(res_mco), 32'd0);
      check("add1_zero", 32'(res_zero), 32'd0);
      tick();

      // ADD wrapping to zero; carry chained through every nibble
      send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      check("add2_data", 32'(res_data), 32'h0000);
      check("add2_mco", 32'(res_mco), 32'd1);
      check("add2_zero", 32'(res_zero), 32'd1);
      check("add2_mcin_seq", 32'(tr_mc), 32'b0111);
      tick();

      // Rotate right: issued MSB-first, bit 0 falls out as rotate carry
      send(OP_ROR, 16'h0001, 16'h0000, 1'b0, 1'b0);
      check("ror1_issue_order", 32'(tr_a), 32'h0001);
      check("ror1_data", 32'(res_data), 32'h0000);
      check("ror1_rco", 32'(res_rco), 32'd1);
      tick();

      send(OP_ROR, 16'h1234, 16'h0000, 1'b0, 1'b1);
      check("ror2_issue_order", 32'(tr_a), 32'h1234);
      check("ror2_data", 32'(res_data), 32'h891A);
      check("ror2_rco", 32'(res_rco), 32'd0);
      tick();

      // Signed overflow on the top nibble
      send(OP_ADD, 16'h7000, 16'h1000, 1'b0, 1'b0);
      check("add3_data", 32'(res_data), 32'h8000);
      check("add3_ovf", 32'(res_ovf), 32'd1);
      tick();

      // Back-pressure: result held for 10 cycles, a command offered meanwhile is ignored
      res_ready = 1'b0;
      send(OP_XOR, 16'hA5A5, 16'h0FF0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 3) begin
            cmd_op = OP_ADD; cmd_a = 16'h1111; cmd_b = 16'h1111; cmd_valid = 1'b1;
         end
         if (i == 4) cmd_valid = 1'b0;
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_data", 32'(res_data), 32'hAA55);
         check("bp_ready", 32'(cmd_ready), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      check("bp_release_ready", 32'(cmd_ready), 32'd1);
      check("bp_release_valid", 32'(res_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("bp_no_ghost", 32'(res_valid), 32'd0);
      end

      // Reset on the second EXEC cycle discards the operation
      cmd_op = OP_ADD; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_mcin = 1'b0; cmd_rcin = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_valid", 32'(res_valid), 32'd0);
      check("midrst_data", 32'(res_data), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("midrst_quiet", 32'(res_valid), 32'd0);
      end
      send(OP_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);
      check("after_rst_data", 32'(res_data), 32'h2345);
      tick();

`ifdef ALU4_SEQ_ABORT_EN
      // Abort on the third EXEC cycle: no result, previous result kept
      cmd_op = OP_ADD; cmd_a = 16'h0F0F; cmd_b = 16'h0101; cmd_mcin = 1'b0; cmd_rcin = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_valid", 32'(res_valid), 32'd0);
      check("abort_data", 32'(res_data), 32'h2345);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_quiet", 32'(res_valid), 32'd0);
      end
      send(OP_XOR, 16'hFFFF, 16'h0F0F, 1'b0, 1'b1);
      check("after_abort_data", 32'(res_data), 32'hF0F0);
      tick();
`endif

      tick(); tick(); tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu4_seq.md
Name: alu4_seq

Overview:
- Multi-precision sequencer for the 4-bit ALU slice.
- Accepts one wide command (opcode plus two NIBBLES×4-bit operands) over a valid/ready handshake.
- Issues the command to the ALU one nibble per cycle, chaining math carry and rotate carry between nibbles, and assembles the wide result and flags.
- Sits between the host/tile I/O and the combinational ALU. It is the only driver of the ALU's opcode, operand and carry inputs.

Parameters:
- NIBBLES, 4, operand width in nibbles (legal 1..8); word width W = 4*NIBBLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode, applied unchanged to every nibble
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- cmd_mcin  in  1  math carry-in for the first nibble
- cmd_rcin  in  1  rotate carry-in for the first nibble
- alu_op  out  4  to ALU opcode
- alu_a  out  4  to ALU operand A nibble
- alu_b  out  4  to ALU operand B nibble
- alu_mcin  out  1  to ALU math carry-in
- alu_rcin  out  1  to ALU rotate carry-in
- alu_out  in  4  ALU result nibble
- alu_mco  in  1  ALU math carry-out
- alu_rco  in  1  ALU rotate carry-out
- alu_ovf  in  1  ALU overflow
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  W  wide result
- res_mco  out  1  final math carry
- res_rco  out  1  final rotate carry
- res_zero  out  1  all result nibbles zero
- res_ovf  out  1  overflow of the final nibble processed

Behaviour:
- States: IDLE, EXEC, DONE.
- Reset (rst_n low at a clk edge) forces state IDLE, nibble counter 0, and clears res_data, all res_* flags, res_valid, alu_op, alu_a, alu_b, alu_mcin and alu_rcin.
- After reset, cmd_ready is 1. Reset asserted mid-EXEC or mid-DONE discards the operation; no result is produced.
- cmd_ready = (state==IDLE). Accept occurs on a clk edge with cmd_valid & cmd_ready.
- On accept, latch op, A, B and carries into operand registers, set the counter to 0, clear the zero accumulator to 1, and go to EXEC.
- Direction per opcode: dir = RIGHT_OPS[cmd_op], taken from the package.
  - dir 0: LSB-first, nibble index k = counter.
  - dir 1: MSB-first, nibble index k = NIBBLES-1-counter.
- EXEC outputs are combinational from registers:
  - alu_op = latched op.
  - alu_a / alu_b = latched nibble k.
  - Counter 0: alu_mcin/alu_rcin = latched cmd carries.
  - Later counts: alu_mcin/alu_rcin = alu_mco/alu_rco registered from the previous EXEC cycle.
  - alu_op, alu_a and alu_b outputs are 0 when not in EXEC.
- Each EXEC edge:
  - store alu_out into result nibble k;
  - register alu_mco and alu_rco;
  - zero_acc &= (alu_out==0);
  - register alu_ovf;
  - increment counter.
- When counter==NIBBLES-1, the EXEC edge moves the block to DONE.
- DONE: res_valid=1; res_* hold the final registered values.
  - A handshake (res_valid & res_ready) returns the block to IDLE.
  - res_data and flags stay stable while res_valid=1 and res_ready=0.
  - res_valid deasserts in IDLE; res_data holds its last value.
- Latency: accept at edge 0, nibbles on cycles 1..NIBBLES, res_valid high from cycle NIBBLES+1. There is no back-to-back overlap.
- Throughput: one command per NIBBLES+2 cycles at minimum (IDLE cycle included).
- NIBBLES=1: a single EXEC cycle. Behaviour is identical to a direct ALU call.
- res_ovf in MSB-first mode reflects the last (LSB) nibble and is defined only for the test plan; the consumer ignores it.

Optional Feature:
- ALU4_SEQ_ABORT_EN
- Enabled: adds input cmd_abort (1 bit).
  - cmd_abort=1 at an edge in EXEC returns the block to IDLE with no res_valid pulse.
  - res_data keeps its previous value.
  - cmd_abort in IDLE or DONE is ignored.
  - Reset has priority over abort.
- Disabled: the port is absent and the behaviour is as above.

Decomposition:
- Package alu4_pkg holds:
  - state enum (IDLE/EXEC/DONE);
  - 16-bit RIGHT_OPS mask, set where the ALU opcode rotates or shifts right;
  - named opcode constants (OP_ADD, OP_SUB, OP_ROR, ...) shared with the ALU and benches.
- One natural sub-module: alu4_seq_nib_mux, a combinational nibble select/insert by index k for W-bit words. It is used for operand fetch and result write-back.

Test Plan:
- Bench ALU model: alu_out = a+b+mcin, with ADD in RIGHT_OPS=0. NIBBLES=4, A=0x00FF, B=0x0001, mcin=0 -> res_data=0x0100, res_mco=0, res_zero=0; res_valid rises exactly 5 cycles after accept.
- ADD with A=0xFFFF, B=0x0001 -> res_data=0x0000, res_mco=1, res_zero=1; per-cycle alu_mcin sequence is 0,1,1,1.
- Right-rotate opcode (RIGHT_OPS=1) with model {rco,out}={a[0],{rcin,a[3:1]}}, A=0x0001, rcin=0 -> nibbles issued in order 3,2,1,0; res_data=0x0000, res_rco=1.
- Back-pressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0. A cmd_valid pulse during this window is not accepted.
- Reset asserted on the 2nd EXEC cycle -> next cycle IDLE, cmd_ready=1, res_valid=0. The next command completes correctly.
- ALU4_SEQ_ABORT_EN: abort on the 3rd EXEC cycle -> no res_valid, IDLE next cycle, res_data unchanged from the prior result.
